// File: rtl/skid_rr_arbiter_pkg.sv
// Shared definitions for the round-robin skid arbiter: FSM encoding and a
// constant clog2 used to validate parameter combinations at elaboration.
package skid_rr_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/skid_rr_arbiter_if.sv
// Bundle of the requester-side and downstream handshakes of the arbiter.
// Handshake rule for every valid/ready pair here: a word moves on a rising
// edge where valid and ready are both high; a producer holds valid and data
// stable until that edge, and valid never waits on ready.
interface skid_rr_arbiter_if #(
    parameter int WORD_WIDTH = 10,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2
);
    import skid_rr_arbiter_pkg::*;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*WORD_WIDTH-1:0] req_data;
    logic                          output_valid;
    logic                          output_ready;
    logic [WORD_WIDTH-1:0]         output_data;
    logic [ID_WIDTH-1:0]           output_id;

    modport master (
        output req_valid, req_data, output_ready,
        input  req_ready, output_valid, output_data, output_id
    );

    modport slave (
        input  req_valid, req_data, output_ready,
        output req_ready, output_valid, output_data, output_id
    );

endinterface

// File: rtl/skid_rr_arbiter_hs_update.sv
// Two-entry pipeline skid buffer: one cycle from input transfer to o_valid,
// full throughput, and one extra word absorbed when i_ready drops.
module skid_rr_arbiter_hs_update #(
    parameter int WIDTH = 12
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);
    logic             r_main_valid;
    logic [WIDTH-1:0] r_main_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_in_fire;
    logic             w_main_free;

    // Ready comes straight from a register so upstream never sees a comb path.
    assign o_ready     = ~r_skid_valid;
    assign w_in_fire   = i_valid & ~r_skid_valid;
    assign w_main_free = ~r_main_valid | i_ready;
    assign o_valid     = r_main_valid;
    assign o_data      = r_main_data;

    always_ff @(posedge clock) begin
        if (clear) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_main_data  <= r_skid_data;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_main_data <= i_data;
                end
            end
        end else if (w_in_fire) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= i_data;
        end
    end

endmodule

// File: rtl/skid_rr_arbiter.sv
// Round-robin arbiter with bounded burst locking that funnels NUM_REQ
// requesters into one skid buffer stage, tagging each word with its source.
module skid_rr_arbiter
    import skid_rr_arbiter_pkg::*;
#(
    parameter int WORD_WIDTH = 10,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int HOLD_MAX   = 4
) (
    input  logic                clock,
    input  logic                clear,
    skid_rr_arbiter_if.slave    bus,
    output state_t              o_state,
    output logic [ID_WIDTH-1:0] o_rr_ptr
);
    localparam int BURST_W = clog2(HOLD_MAX + 1);
    localparam int SKID_W  = WORD_WIDTH + ID_WIDTH;

    if (ID_WIDTH != clog2(NUM_REQ)) begin : g_bad_id_width
        $error("ID_WIDTH must equal clog2(NUM_REQ)");
    end
    if (NUM_REQ < 2 || HOLD_MAX < 1) begin : g_bad_sizes
        $error("NUM_REQ must be >= 2 and HOLD_MAX >= 1");
    end

    state_t              r_state, w_state_nxt;
    logic [ID_WIDTH-1:0] r_rr_ptr, w_rr_ptr_nxt;
    logic [ID_WIDTH-1:0] r_grant_q, w_grant_nxt;
    logic [BURST_W-1:0]  r_burst_cnt, w_burst_nxt;
    logic [NUM_REQ-1:0]  w_req_ready;
    logic                w_grant_valid;
    logic                w_skid_in_valid;
    logic                w_skid_in_ready;
    logic [SKID_W-1:0]   w_skid_in_data;
    logic                w_skid_out_valid;
    logic [SKID_W-1:0]   w_skid_out_data;
    logic                w_in_fire;
    logic [ID_WIDTH-1:0] w_release_ptr;
    logic [WORD_WIDTH-1:0] w_req_words [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_req_words[g] = bus.req_data[g*WORD_WIDTH +: WORD_WIDTH];
    end

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    function automatic logic [ID_WIDTH-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                    input logic [ID_WIDTH-1:0] ptr);
        logic [ID_WIDTH-1:0] pick;
        logic [ID_WIDTH-1:0] idx;
        logic                found;
        int                  sum;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = int'(ptr) + i;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = ID_WIDTH'(sum);
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_release_ptr = (r_grant_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : r_grant_q + ID_WIDTH'(1);

    always_comb begin
        w_grant_valid   = bus.req_valid[r_grant_q];
        w_skid_in_valid = 1'b0;
        w_req_ready     = '0;
        w_skid_in_data  = {r_grant_q, w_req_words[r_grant_q]};
        // Nothing is accepted while clear is high, so a requester keeps its word.
        if (r_state == LOCKED && !clear) begin
            w_skid_in_valid         = w_grant_valid;
            w_req_ready[r_grant_q]  = w_skid_in_ready;
        end
        w_in_fire    = w_skid_in_valid & w_skid_in_ready;
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_grant_nxt  = r_grant_q;
        w_burst_nxt  = r_burst_cnt;
        case (r_state)
            IDLE: begin
                if (|bus.req_valid) begin
                    w_grant_nxt = rr_pick(bus.req_valid, r_rr_ptr);
                    w_burst_nxt = '0;
                    w_state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (!w_grant_valid) begin
                    w_rr_ptr_nxt = w_release_ptr;
                    w_state_nxt  = IDLE;
                end else if (w_in_fire) begin
                    if (r_burst_cnt == BURST_W'(HOLD_MAX - 1)) begin
                        w_rr_ptr_nxt = w_release_ptr;
                        w_state_nxt  = IDLE;
                    end else begin
                        w_burst_nxt = r_burst_cnt + BURST_W'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant_q   <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_grant_q   <= w_grant_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    skid_rr_arbiter_hs_update #(
        .WIDTH (SKID_W)
    ) u_hs_update (
        .clock   (clock),
        .clear   (clear),
        .i_valid (w_skid_in_valid),
        .o_ready (w_skid_in_ready),
        .i_data  (w_skid_in_data),
        .o_valid (w_skid_out_valid),
        .i_ready (bus.output_ready),
        .o_data  (w_skid_out_data)
    );

    assign bus.req_ready    = w_req_ready;
    assign bus.output_valid = w_skid_out_valid & ~clear;
    assign bus.output_data  = clear ? '0 : w_skid_out_data[WORD_WIDTH-1:0];
    assign bus.output_id    = clear ? '0 : w_skid_out_data[SKID_W-1:WORD_WIDTH];
    assign o_state          = r_state;
    assign o_rr_ptr         = r_rr_ptr;

endmodule
